// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main control FSM with memory-ready stalls, trap on illegal op or memory timeout,
// and a retired-instruction counter. Define MC_CTRL_IMM_OPS_EN to add ADDI (IMM_EX/IMM_WB states).
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           op,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic [3:0]           state,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EX   = 4'd10,
    S_IMM_WB   = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_IMM_OPS_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t               state_q, state_d;
  logic [7:0]           wait_q;
  logic                 is_sw_q;
  logic                 trap_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 mem_state;
  logic                 stall_expire;
  logic                 retire;

  assign mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Last permitted stall cycle: one more cycle without ready means the access has timed out.
  assign stall_expire = mem_state && !mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));
  assign retire       = (state_d == S_FETCH) &&
                        (state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB});

  assign state   = state_q;
  assign trap    = trap_q;
  assign retired = retired_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      is_sw_q   <= 1'b0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || mem_ready)
        wait_q <= '0;
      else if (mem_state)
        wait_q <= wait_q + 8'd1;
      if (state_q == S_DECODE)
        is_sw_q <= (op == OP_SW);
      if (state_d == S_TRAP)
        trap_q <= 1'b1;
      if (retire)
        retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_IMM_OPS_EN
          OP_ADDI:      state_d = S_IMM_EX;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
`ifdef MC_CTRL_IMM_OPS_EN
      S_IMM_EX:   state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
`endif
      default:    state_d = S_TRAP;
    endcase
    if (stall_expire)
      state_d = S_TRAP;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   ALUSrcB = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
`ifdef MC_CTRL_IMM_OPS_EN
        S_IMM_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_IMM_WB:   RegWrite = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: an instruction-level model expands each instruction into its expected
// per-cycle state/control trace; a negedge monitor pops and compares against the DUT.
module tb_mc_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
  } ctl_t;

  typedef struct {
    int          st;
    ctl_t        ctl;
    logic        trap;
    logic [CW-1:0] ret;
  } exp_t;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_J, K_ADDI, K_ILL} kind_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    op = '0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, ALUOp, PCSource;
  logic [3:0]    state;
  logic          trap;
  logic [CW-1:0] retired;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] m_ret     = '0;
  bit            m_trapped = 1'b0;

  mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic ctl_t exp_ctl(input int st, input logic mr);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: c.reg_write = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic kind_t classify(input logic [5:0] o);
    case (o)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
`ifdef MC_CTRL_IMM_OPS_EN
      6'b001000: return K_ADDI;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rmr();
    return 1'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the expected observation for that cycle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic mr, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; op = o; mem_ready = mr;
    e.st   = st;
    e.ctl  = r ? ctl_t'('0) : exp_ctl(st, mr);
    e.trap = m_trapped;
    e.ret  = m_ret;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ctl_t act;
      e   = sb.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
      check("state", {28'b0, state}, 32'(e.st));
      check("controls", {16'b0, act}, {16'b0, e.ctl});
      check("trap", {31'b0, trap}, {31'b0, e.trap});
      check("retired", {28'b0, retired}, {28'b0, e.ret});
    end
  end

  task automatic do_reset(input int n);
    cyc(1'b1, rop(), rmr(), m_trapped ? 15 : 0);
    m_trapped = 1'b0;
    m_ret     = '0;
    for (int i = 1; i < n; i++) cyc(1'b1, rop(), rmr(), 0);
  endtask

  // A memory-wait state: s stall cycles then ready, or a timeout trap when s reaches the limit.
  task automatic mem_phase(input int st, input int s, output bit tripped);
    tripped = 1'b0;
    if (s >= TO) begin
      for (int i = 0; i < TO; i++) cyc(1'b0, rop(), 1'b0, st);
      m_trapped = 1'b1;
      tripped   = 1'b1;
    end else begin
      for (int i = 0; i < s; i++) cyc(1'b0, rop(), 1'b0, st);
      cyc(1'b0, rop(), 1'b1, st);
    end
  endtask

  task automatic run_instr(input logic [5:0] opc, input int sf, input int sm, input bit abort_wr);
    bit    tripped;
    kind_t k;
    k = classify(opc);
    mem_phase(0, sf, tripped);
    if (tripped) return;
    cyc(1'b0, opc, rmr(), 1);
    case (k)
      K_R:   begin cyc(1'b0, rop(), rmr(), 6); cyc(1'b0, rop(), rmr(), 7); m_ret++; end
      K_LW: begin
        cyc(1'b0, rop(), rmr(), 2);
        mem_phase(3, sm, tripped);
        if (tripped) return;
        cyc(1'b0, rop(), rmr(), 4);
        m_ret++;
      end
      K_SW: begin
        cyc(1'b0, rop(), rmr(), 2);
        if (abort_wr) begin
          cyc(1'b1, rop(), 1'b0, 5);
          m_ret = '0;
          return;
        end
        mem_phase(5, sm, tripped);
        if (tripped) return;
        m_ret++;
      end
      K_BEQ:  begin cyc(1'b0, rop(), rmr(), 8); m_ret++; end
      K_J:    begin cyc(1'b0, rop(), rmr(), 9); m_ret++; end
      K_ADDI: begin cyc(1'b0, rop(), rmr(), 10); cyc(1'b0, rop(), rmr(), 11); m_ret++; end
      default: m_trapped = 1'b1;
    endcase
  endtask

  task automatic recover();
    if (m_trapped) begin
      for (int i = 0; i < 3; i++) cyc(1'b0, rop(), rmr(), 15);
      do_reset(2);
    end
  endtask

  task automatic instr(input logic [5:0] opc, input int sf, input int sm, input bit abort_wr);
    run_instr(opc, sf, sm, abort_wr);
    recover();
  endtask

  initial begin
    do_reset(2);
    instr(6'b000000, 0, 0, 0);
    instr(6'b100011, 0, 3, 0);
    instr(6'b101011, 1, 2, 0);
    instr(6'b000100, 2, 0, 0);
    instr(6'b000010, 0, 0, 0);
    instr(6'b111111, 0, 0, 0);
    instr(6'b000000, TO, 0, 0);
    instr(6'b100011, 3, TO, 0);
    instr(6'b101011, 0, TO, 0);
    instr(6'b001000, 0, 0, 0);
    instr(6'b000010, 0, 0, 0);
    do_reset(1);
    for (int i = 0; i < 17; i++) instr(6'b000010, 0, 0, 0);
    instr(6'b000000, 0, 0, 0);
    instr(6'b101011, 1, 0, 1);
    instr(6'b000100, 0, 0, 0);

    for (int n = 0; n < 120; n++) begin
      logic [5:0] o;
      int sf, sm;
      case ($urandom_range(0, 9))
        0, 1: o = 6'b000000;
        2, 8: o = 6'b100011;
        3, 9: o = 6'b101011;
        4:    o = 6'b000100;
        5:    o = 6'b000010;
        6:    o = 6'b001000;
        default: o = rop();
      endcase
      sf = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, TO - 1));
      sm = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, TO - 1));
      instr(o, sf, sm, $urandom_range(0, 15) == 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main control unit for the MIPS datapath.
- Replaces the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and stalls on a memory ready handshake.
- Traps on an illegal opcode or a memory timeout, and counts retired instructions.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive stall cycles in any memory state before trapping. Range 1..255.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode, IR[31:26]. Sampled in DECODE only.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero.
- IorD  out  1  memory address source: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back source: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A source: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU B source: 00=rt, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct.
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target.
- state  out  4  current state encoding, for debug.
- trap  out  1  sticky error flag.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EX=10, IMM_WB=11, TRAP=15.
- Reset: state=FETCH, wait counter=0, trap=0, retired=0. While rst=1, every control output is forced to 0.
- Outputs are decoded from state. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1.
  - mem_ready=1 -> DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcB=11, ALUOp=00. Next state by op:
  - 000000 -> EXEC_R
  - 100011, 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other op -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEM_RD, SW -> MEM_WR. The op value is latched in DECODE.
- MEM_RD: MemRead=1, IorD=1. mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. mem_ready -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> R_WB.
- R_WB: RegWrite=1, RegDst=1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- JUMP: PCWrite=1, PCSource=10. -> FETCH.
- Wait counter (applies in FETCH, MEM_RD, MEM_WR):
  - Increments each cycle mem_ready=0. Clears on mem_ready=1 and on any state change.
  - Counter reaches MEM_TIMEOUT while mem_ready is still 0 -> TRAP on the next edge.
- TRAP: all control outputs 0, trap=1. Held until rst.
- retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or IMM_WB.
  - Wraps modulo 2^CNT_WIDTH.
  - Frozen in TRAP.
- rst mid-instruction: on the next edge, return to FETCH with all counters and trap cleared. The aborted instruction is not counted.
- Nominal latency (zero wait): LW=5, SW=4, R=4, BEQ=3, J=3 cycles.

Optional Feature:
- Macro: MC_CTRL_IMM_OPS_EN.
- Defined: op 001000 (ADDI) in DECODE -> IMM_EX.
  - IMM_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> IMM_WB.
  - IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH; counted as retired.
  - ADDI takes 4 cycles.
- Undefined: 001000 is illegal -> TRAP. States 10 and 11 are unreachable.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1, op=000000 -> state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 in state 7. retired=1 after 4 cycles.
- op=100011, mem_ready low for 3 cycles in MEM_RD -> state held at 3 for 3 extra cycles. MemRead=1 and IorD=1 throughout. Then 4 then 0. retired increments once.
- MEM_TIMEOUT=4, mem_ready=0 held in FETCH -> TRAP (state=15, trap=1) after the 4th stall cycle. All controls 0. Stays in TRAP until rst.
- op=111111 in DECODE -> TRAP. With MC_CTRL_IMM_OPS_EN defined, op=001000 -> states 10,11,0 and RegWrite=1 with MemtoReg=0 in state 11.
- CNT_WIDTH=4, 16 back-to-back JUMP instructions -> retired wraps to 0. PCWrite=1 and PCSource=10 in each state 9.
- Assert rst in MEM_WR with mem_ready=0 -> next cycle state=0, retired unchanged from its pre-instruction value (or 0 after reset), MemWrite=0.
